// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_run_ctrl
//  Purpose  : Execution controller for the pipelined MIPS core. Gates the
//             global pipeline enable from the board run switch, and sequences
//             free-run, single-step, breakpoint pause and syscall halt. It also
//             keeps the cycle and retired-instruction counters and registers
//             the value shown on the LEDs.
//  Options  : RUN_CTRL_BP_EN - when defined, the PC breakpoint comparator and
//             its resume-skip flag are built. When undefined, bp_en and
//             bp_addr are accepted but have no effect.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_run_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int IM_BUS_WIDTH = 10,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    raw_clk,
  input  logic                    raw_rst,
  input  logic                    raw_en,
  input  logic                    step,
  input  logic                    halt_req,
  input  logic                    retire,
  input  logic [IM_BUS_WIDTH-1:0] pc,
  input  logic                    bp_en,
  input  logic [IM_BUS_WIDTH-1:0] bp_addr,
  input  logic                    show_req,
  input  logic [DATA_WIDTH-1:0]   show_data,
  input  logic [1:0]              led_sel,
  output logic                    core_en,
  output logic [1:0]              state,
  output logic [CNT_WIDTH-1:0]    cycle_cnt,
  output logic [CNT_WIDTH-1:0]    retire_cnt,
  output logic [DATA_WIDTH-1:0]   led_data
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;

  logic [1:0]            state_q, state_d;
  logic                  raw_en_q;
  logic                  en_rise;
  logic                  bp_hit;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  retire_q, retire_d;
  logic [DATA_WIDTH-1:0] disp_q, disp_d;
  logic [DATA_WIDTH-1:0] led_q, led_d;
  logic [DATA_WIDTH-1:0] pc_ext;

  assign en_rise = raw_en & ~raw_en_q;

  // The pipeline runs in RUN unless parked on a breakpoint, and for the single STEP cycle.
  assign core_en = ((state_q == ST_RUN) & ~bp_hit) | (state_q == ST_STEP);

`ifdef RUN_CTRL_BP_EN
  logic skip_q, skip_d;

  // The first cycle after entering RUN/STEP ignores the breakpoint, so a resume
  // can move off the address it stopped on.
  assign bp_hit = (state_q == ST_RUN) & bp_en & (pc == bp_addr) & ~skip_q;

  // Skip is raised on each entry into RUN or STEP and lasts one cycle.
  always_comb begin
    skip_d = (state_d != state_q) & ((state_d == ST_RUN) | (state_d == ST_STEP));
  end

  // Skip flag register.
  always_ff @(posedge raw_clk or posedge raw_rst) begin
    if (raw_rst) skip_q <= 1'b0;
    else         skip_q <= skip_d;
  end
`else
  logic bp_unused;
  assign bp_hit    = 1'b0;
  assign bp_unused = ^{bp_en, bp_addr};
`endif

  // Controller next state. halt_req only counts while the core is enabled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en_rise)   state_d = ST_RUN;
        else if (step) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (halt_req & core_en) state_d = ST_HALT;
        else if (bp_hit)        state_d = ST_IDLE;
        else if (!raw_en)       state_d = ST_IDLE;
      end
      ST_STEP: begin
        if (halt_req) state_d = ST_HALT;
        else          state_d = ST_IDLE;
      end
      default: state_d = ST_HALT;
    endcase
  end

  generate
    if (DATA_WIDTH >= IM_BUS_WIDTH) begin : g_pc_pad
      // Zero-extend the PC into the display width.
      always_comb begin
        pc_ext = '0;
        pc_ext[IM_BUS_WIDTH-1:0] = pc;
      end
    end else begin : g_pc_trunc
      assign pc_ext = pc[DATA_WIDTH-1:0];
    end
  endgenerate

  // Counters, the display latch and the LED source mux. Counters wrap naturally.
  always_comb begin
    cycle_d  = cycle_q;
    retire_d = retire_q;
    disp_d   = disp_q;
    if (core_en) begin
      cycle_d = cycle_q + CNT_WIDTH'(1);
      if (retire)   retire_d = retire_q + CNT_WIDTH'(1);
      if (show_req) disp_d   = show_data;
    end
    case (led_sel)
      2'b00:   led_d = disp_q;
      2'b01:   led_d = cycle_q[DATA_WIDTH-1:0];
      2'b10:   led_d = retire_q[DATA_WIDTH-1:0];
      default: led_d = pc_ext;
    endcase
  end

  // All controller state, cleared asynchronously by raw_rst.
  always_ff @(posedge raw_clk or posedge raw_rst) begin
    if (raw_rst) begin
      state_q  <= ST_IDLE;
      raw_en_q <= 1'b0;
      cycle_q  <= '0;
      retire_q <= '0;
      disp_q   <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      raw_en_q <= raw_en;
      cycle_q  <= cycle_d;
      retire_q <= retire_d;
      disp_q   <= disp_d;
      led_q    <= led_d;
    end
  end

  assign state      = state_q;
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
  assign led_data   = led_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_run_ctrl
//  Purpose  : Randomised scoreboard bench for mips_run_ctrl, plus a narrow
//             4-bit instance used to exercise counter wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_run_ctrl;

`ifdef RUN_CTRL_BP_EN
  localparam bit BP_BUILT = 1'b1;
`else
  localparam bit BP_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        raw_rst, raw_en, step, halt_req, retire, bp_en, show_req;
  logic [9:0]  pc, bp_addr;
  logic [31:0] show_data;
  logic [1:0]  led_sel;
  logic        core_en;
  logic [1:0]  state;
  logic [31:0] cycle_cnt, retire_cnt, led_data;

  logic        s_rst, s_en, s_core_en;
  logic [1:0]  s_state;
  logic [3:0]  s_cycle, s_retire, s_led;

  always #5 clk = ~clk;

  mips_run_ctrl u_dut (
    .raw_clk(clk), .raw_rst(raw_rst), .raw_en(raw_en), .step(step),
    .halt_req(halt_req), .retire(retire), .pc(pc), .bp_en(bp_en),
    .bp_addr(bp_addr), .show_req(show_req), .show_data(show_data),
    .led_sel(led_sel), .core_en(core_en), .state(state),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .led_data(led_data)
  );

  mips_run_ctrl #(.DATA_WIDTH(4), .IM_BUS_WIDTH(4), .CNT_WIDTH(4)) u_small (
    .raw_clk(clk), .raw_rst(s_rst), .raw_en(s_en), .step(1'b0),
    .halt_req(1'b0), .retire(1'b1), .pc(4'h3), .bp_en(1'b0),
    .bp_addr(4'h0), .show_req(1'b0), .show_data(4'h0),
    .led_sel(2'b01), .core_en(s_core_en), .state(s_state),
    .cycle_cnt(s_cycle), .retire_cnt(s_retire), .led_data(s_led)
  );

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_RUN, M_STEP, M_HALT} mstate_t;
  typedef struct {
    logic [1:0]  st;
    logic        ce;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [31:0] led;
  } exp_t;

  exp_t        sb[$];
  mstate_t     m_st;
  bit          m_prev_en, m_fresh;
  logic [31:0] m_cyc, m_ret, m_disp, m_led;

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [1:0] code_of(mstate_t s);
    case (s)
      M_IDLE:  return 2'b00;
      M_RUN:   return 2'b01;
      M_STEP:  return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_prev_en = 0; m_fresh = 0;
    m_cyc = 0; m_ret = 0; m_disp = 0; m_led = 0;
  endtask

  // Inputs for the current cycle are already applied; push this cycle's
  // expected outputs and advance the model across the next rising edge.
  task automatic model_cycle();
    exp_t    e;
    bit      hit, ce;
    mstate_t nxt;
    if (raw_rst) begin
      model_reset();
      e = '{2'b00, 1'b0, 32'd0, 32'd0, 32'd0};
      sb.push_back(e);
      return;
    end
    hit = BP_BUILT && m_st == M_RUN && bp_en && pc == bp_addr && !m_fresh;
    ce  = (m_st == M_RUN && !hit) || m_st == M_STEP;
    e = '{code_of(m_st), ce, m_cyc, m_ret, m_led};
    sb.push_back(e);
    case (led_sel)
      2'd0:    m_led = m_disp;
      2'd1:    m_led = m_cyc;
      2'd2:    m_led = m_ret;
      default: m_led = 32'(pc);
    endcase
    if (ce) begin
      m_cyc = m_cyc + 1;
      if (retire)   m_ret  = m_ret + 1;
      if (show_req) m_disp = show_data;
    end
    nxt = m_st;
    case (m_st)
      M_IDLE: if (raw_en && !m_prev_en) nxt = M_RUN; else if (step) nxt = M_STEP;
      M_RUN:  if (halt_req && ce) nxt = M_HALT; else if (hit || !raw_en) nxt = M_IDLE;
      M_STEP: nxt = halt_req ? M_HALT : M_IDLE;
      default: nxt = M_HALT;
    endcase
    m_fresh   = (nxt != m_st) && (nxt == M_RUN || nxt == M_STEP);
    m_prev_en = raw_en;
    m_st      = nxt;
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("state",      32'(state),   32'(e.st));
        cmp("core_en",    32'(core_en), 32'(e.ce));
        cmp("cycle_cnt",  cycle_cnt,    e.cyc);
        cmp("retire_cnt", retire_cnt,   e.ret);
        cmp("led_data",   led_data,     e.led);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic randomize_inputs(int phase);
    if ($urandom_range(0, 7) == 0) raw_en = ~raw_en;
    step      = ($urandom_range(0, 5) == 0);
    halt_req  = ($urandom_range(0, 79) == 0);
    retire    = $urandom_range(0, 1);
    show_req  = ($urandom_range(0, 3) == 0);
    show_data = $urandom;
    led_sel   = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 1) == 0) pc = 10'($urandom_range(13, 19));
    raw_rst   = (phase > 0) && ($urandom_range(0, 249) == 0);
  endtask

  initial begin
    raw_rst = 1; raw_en = 1; step = 0; halt_req = 0; retire = 1;
    pc = 10'h0; bp_en = 1; bp_addr = 10'h010; show_req = 0;
    show_data = 0; led_sel = 2'b01;
    s_rst = 1; s_en = 0;
    model_reset();

    // run switch held high through reset, then free running with sel=01
    for (int c = 0; c < 2; c++) begin @(negedge clk); #1; model_cycle(); end
    @(negedge clk); raw_rst = 0; #1; model_cycle();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); pc = pc + 10'd1; #1; model_cycle();
    end

    for (int phase = 0; phase < 8; phase++) begin
      @(negedge clk);
      raw_rst = 1; raw_en = $urandom_range(0, 1);
      bp_en = (phase % 2 == 0); bp_addr = 10'h010;
      #1; model_cycle();
      @(negedge clk); raw_rst = 0; #1; model_cycle();
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        randomize_inputs(phase);
        #1; model_cycle();
      end
    end

    @(negedge clk); #3;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end

    // narrow instance: counter wrap and asynchronous reset mid-run
    s_en = 1;
    @(negedge clk); s_rst = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      cmp("w_state",   32'(s_state),   32'd1);
      cmp("w_core_en", 32'(s_core_en), 32'd1);
      cmp("w_cycle",   32'(s_cycle),   32'((k - 1) % 16));
      cmp("w_retire",  32'(s_retire),  32'((k - 1) % 16));
      if (k >= 2) cmp("w_led", 32'(s_led), 32'((k - 2) % 16));
    end
    @(negedge clk); #2; s_rst = 1; #1;
    cmp("w_rst_core_en", 32'(s_core_en), 32'd0);
    cmp("w_rst_state",   32'(s_state),   32'd0);
    cmp("w_rst_cycle",   32'(s_cycle),   32'd0);
    cmp("w_rst_led",     32'(s_led),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
